// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern generator with rotate, bounce, fill and hold modes
module led_sequencer #(
  parameter int N_LEDS = 4,
  parameter int CNT_W = 22,
  parameter logic [CNT_W-1:0] DIVIDER = 22'd1000000
) (
  input  logic              CLK_3p33MHZ,
  input  logic              RST,
  input  logic [1:0]        MODE,
  input  logic [1:0]        SPEED,
  output logic [N_LEDS-1:0] LEDS,
  output logic              STEP
);
  typedef enum logic [1:0] {ROTATE = 2'b00, BOUNCE = 2'b01, FILL = 2'b10, HOLD = 2'b11} mode_e;
  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);
  mode_e             mode_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, term;
  logic              tick_q, tick_d, step_q, step_d, dir_q, dir_d;
  logic [N_LEDS-1:0] leds_q, leds_d, inc, rot, bnc, fil, adv;
  logic              wrap, chg, hot, thermo, full, bdir;
  // prescaler, pattern advance and mode-change restart
  always_comb begin
    term   = DIVIDER >> SPEED;
    wrap   = cnt_q >= term;
    chg    = MODE != mode_q;
    inc    = leds_q + 1'b1;
    hot    = (leds_q != '0) && ((leds_q & (leds_q - 1'b1)) == '0);
    thermo = (leds_q != '0) && ((leds_q & inc) == '0);
    full   = &leds_q;
    bdir   = leds_q[N_LEDS-1] ? 1'b0 : (leds_q[0] ? 1'b1 : dir_q);
    rot    = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
    bnc    = bdir ? leds_q << 1 : leds_q >> 1;
    fil    = {leds_q[N_LEDS-2:0], 1'b1};
    adv    = mode_q == ROTATE ? (hot ? rot : ONE) :
             mode_q == BOUNCE ? (hot ? bnc : ONE) :
             mode_q == FILL   ? (thermo && !full ? fil : ONE) : leds_q;
    cnt_d  = chg ? '0 : (wrap ? '0 : cnt_q + 1'b1);
    tick_d = !chg && wrap;
    step_d = tick_d && mode_q != HOLD;
    leds_d = chg ? ONE : (tick_q ? adv : leds_q);
    dir_d  = chg ? 1'b1 : (tick_q && mode_q == BOUNCE ? (hot ? bdir : 1'b1) : dir_q);
  end
  // state registers with synchronous reset
  always_ff @(posedge CLK_3p33MHZ) begin
    mode_q <= mode_e'(MODE);
    if (RST) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      step_q <= 1'b0;
      leds_q <= ONE;
      dir_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      step_q <= step_d;
      leds_q <= leds_d;
      dir_q  <= dir_d;
    end
  end
  assign LEDS = leds_q;
  assign STEP = step_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed checks of prescaler timing and all LED pattern modes
module tb_led_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic [1:0] mode_a = 2'b00, speed_a = 2'b00, mode_b = 2'b00, speed_b = 2'b00;
  logic [3:0] leds_a, leds_b;
  logic step_a, step_b;
  int tests = 0, fails = 0;
  int s, hs, hl;
  led_sequencer #(.N_LEDS(4), .CNT_W(22), .DIVIDER(22'd3)) dut_a (
    .CLK_3p33MHZ(clk), .RST(rst_a), .MODE(mode_a), .SPEED(speed_a), .LEDS(leds_a), .STEP(step_a)
  );
  led_sequencer #(.N_LEDS(4), .CNT_W(8), .DIVIDER(8'd15)) dut_b (
    .CLK_3p33MHZ(clk), .RST(rst_b), .MODE(mode_b), .SPEED(speed_b), .LEDS(leds_b), .STEP(step_b)
  );
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_step(input string tag, input bit b, input int gap);
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while (!(b ? step_b : step_a) && n < 40);
    chk(tag, n, gap);
  endtask
  task automatic adv(input string tag, input int gap, input logic [3:0] exp);
    wait_step(tag, 1'b0, gap);
    cyc(1);
    chk(tag, leds_a, exp);
  endtask
  initial begin
    cyc(2);
    chk("rst_leds_a", leds_a, 4'b0001);
    chk("rst_step_a", step_a, 1'b0);
    chk("rst_leds_b", leds_b, 4'b0001);
    rst_b = 1'b0;
    s = 0;
    repeat (9) begin
      cyc(1);
      s += step_b;
    end
    chk("b_no_step_before_cnt9", s, 0);
    speed_b = 2'b10;
    cyc(1);
    chk("b_speed_change_tick", step_b, 1'b1);
    wait_step("b_speed2_gap", 1'b1, 4);
    chk("b_leds_after_first", leds_b, 4'b0010);
    speed_b = 2'b11;
    wait_step("b_speed3_gap1", 1'b1, 2);
    wait_step("b_speed3_gap2", 1'b1, 2);
    rst_b = 1'b1;
    rst_a = 1'b0;
    adv("rot1", 4, 4'b0010);
    adv("rot2", 3, 4'b0100);
    adv("rot3", 3, 4'b1000);
    adv("rot4", 3, 4'b0001);
    mode_a = 2'b01;
    cyc(1);
    chk("bnc_enter", leds_a, 4'b0001);
    adv("bnc1", 4, 4'b0010);
    adv("bnc2", 3, 4'b0100);
    adv("bnc3", 3, 4'b1000);
    adv("bnc4", 3, 4'b0100);
    adv("bnc5", 3, 4'b0010);
    adv("bnc6", 3, 4'b0001);
    adv("bnc7", 3, 4'b0010);
    mode_a = 2'b10;
    cyc(1);
    chk("fill_enter", leds_a, 4'b0001);
    adv("fill1", 4, 4'b0011);
    adv("fill2", 3, 4'b0111);
    adv("fill3", 3, 4'b1111);
    adv("fill4", 3, 4'b0001);
    mode_a = 2'b00;
    cyc(1);
    chk("rot_enter", leds_a, 4'b0001);
    adv("rot_h1", 4, 4'b0010);
    adv("rot_h2", 3, 4'b0100);
    mode_a = 2'b11;
    cyc(1);
    chk("hold_enter", leds_a, 4'b0001);
    chk("hold_enter_step", step_a, 1'b0);
    hs = 0;
    hl = 0;
    repeat (12) begin
      cyc(1);
      hs += step_a;
      hl += (leds_a != 4'b0001) ? 1 : 0;
    end
    chk("hold_no_step", hs, 0);
    chk("hold_frozen", hl, 0);
    mode_a = 2'b00;
    cyc(1);
    chk("hold_exit", leds_a, 4'b0001);
    adv("hold_exit_restart", 4, 4'b0010);
    mode_a = 2'b01;
    cyc(1);
    chk("bnc2_enter", leds_a, 4'b0001);
    adv("bnc2_1", 4, 4'b0010);
    adv("bnc2_2", 3, 4'b0100);
    adv("bnc2_3", 3, 4'b1000);
    adv("bnc2_4", 3, 4'b0100);
    cyc(3);
    chk("pre_rst_tick", step_a, 1'b1);
    rst_a = 1'b1;
    cyc(1);
    chk("rst_tick_leds", leds_a, 4'b0001);
    chk("rst_tick_step", step_a, 1'b0);
    rst_a = 1'b0;
    adv("post_rst1", 4, 4'b0010);
    adv("post_rst2", 3, 4'b0100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter N_LEDS, default 4: number of LED outputs, legal range 2..32.
REQ-002 Parameter DIVIDER, default 22'd1000000: base terminal count of the step prescaler, giving one step per DIVIDER+1 clocks at SPEED=0.
REQ-003 Parameter CNT_W, default 22: prescaler counter width; DIVIDER SHALL fit in CNT_W bits.
REQ-004 CLK_3p33MHZ  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 MODE  input  2  pattern select: 00 rotate, 01 bounce, 10 fill, 11 hold.
REQ-007 SPEED  input  2  rate select; effective terminal count TERM = DIVIDER >> SPEED.
REQ-008 LEDS  output  N_LEDS  registered LED pattern; bit 0 is the first LED in the chain.
REQ-009 STEP  output  1  registered one-clock pulse that marks each pattern advance.

Function
REQ-010 Prescaler: if cnt >= TERM, then cnt <= 0 and tick <= 1; else cnt <= cnt+1 and tick <= 0. The >= compare makes a SPEED change take effect on the next clock with no overrun.
REQ-011 tick is high for exactly one clock per TERM+1 clocks; TERM=0 SHALL give tick high every clock.
REQ-012 The pattern SHALL advance only in a clock where tick==1, so LEDS changes one clock after the tick is registered; there is no derived clock.
REQ-013 STEP SHALL equal tick delayed by zero cycles (STEP = tick register), and it SHALL be forced to 0 in hold mode.
REQ-014 Rotate (00): on each advance, LEDS <= {LEDS[N_LEDS-2:0], LEDS[N_LEDS-1]}; bit N_LEDS-1 wraps to bit 0.
REQ-015 Bounce (01): a one-hot position moves with a dir flag (1 = toward MSB). At bit N_LEDS-1 the next move SHALL go toward LSB, and at bit 0 the next move SHALL go toward MSB. End positions are shown for one step only (e.g. 0,1,2,3,2,1,0,1 for N_LEDS=4).
REQ-016 Fill (10): on each advance, LEDS <= {LEDS[N_LEDS-2:0],1'b1}; when LEDS is all-ones, the next advance SHALL load 0...01.
REQ-017 Hold (11): LEDS SHALL be frozen and the prescaler SHALL keep counting.
REQ-018 Mode change detection: mode_q registers MODE every clock. When MODE != mode_q, the block SHALL, in that clock:
  - load LEDS to 0...01;
  - set dir to 1;
  - set cnt to 0 and tick to 0.
  A mode change SHALL take priority over a simultaneous tick.
REQ-019 Entering hold via a mode change SHALL also load 0...01, and that pattern then stays frozen.
REQ-020 Pattern legality: if LEDS is not one-hot in rotate or bounce mode, the next advance SHALL load 0...01.
REQ-021 Pattern legality: if LEDS is not a thermometer code (0..01 .. 1..11) in fill mode, the next advance SHALL load 0...01.
REQ-022 Arithmetic: cnt is CNT_W bits unsigned, and the >= TERM compare prevents wrap-around.

Reset
REQ-023 While RST=1 at a clock edge: cnt=0, tick=0, STEP=0, LEDS=0...01, dir=1, mode_q<=MODE.
REQ-024 RST SHALL override all other activity, including a mid-sequence tick or mode change.
REQ-025 After RST deasserts, the first advance SHALL occur TERM+1 clocks later.

Verification
REQ-026 N_LEDS=4, DIVIDER=3, SPEED=0, MODE=00, release RST -> STEP every 4 clocks; LEDS sequence 0001,0010,0100,1000,0001.
REQ-027 MODE=01, same parameters -> LEDS 0001,0010,0100,1000,0100,0010,0001,0010; no position repeats at the ends.
REQ-028 MODE=10 -> LEDS 0001,0011,0111,1111,0001.
REQ-029 Switch MODE 00->11 while LEDS=0100, then 11->00 -> LEDS=0001 on the clock after each change; LEDS frozen while in hold; STEP stays 0 in hold; cnt restarts at 0 after each change.
REQ-030 DIVIDER=15, SPEED 0->2 while cnt=9 -> tick on the next clock (9>=3), then every 4 clocks; SPEED=3 gives TERM=1, a step every 2 clocks.
REQ-031 Assert RST for 1 clock coincident with a tick in bounce mode with dir=0 -> LEDS=0001, dir=1, STEP=0 that clock; the next advance comes 4 clocks after RST falls (DIVIDER=3).
